// File: rtl/res_pack.sv
// Rounding and packing back end of a single-precision multiplier.
// S1 classifies and normalizes the product; S2 rounds, packs and holds the output.
module res_pack (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        res_sign,
   input  logic [1:0]  res_NANs,
   input  logic        res_INF,
   input  logic        res_ZERO,
   input  logic [47:0] prod_man,
   input  logic [9:0]  exp_sum,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_flags
);

   typedef struct packed {
      logic        sign;
      logic        nan;
      logic        invalid;
      logic        inf;
      logic        zero;
      logic [22:0] man;
      logic        guard;
      logic        sticky;
      logic [10:0] exp;
   } s1_t;

   logic        s1_valid_q, s1_valid_d;
   s1_t         s1_q, s1_d, s1_new;
   logic        s2_valid_q, s2_valid_d;
   logic [31:0] data_q, data_d, data_pk;
   logic [3:0]  flags_q, flags_d, flags_pk;

   logic        advance;
   logic        norm_hi;

   logic        round_up;
   logic [23:0] man_rnd;
   logic signed [10:0] exp_s1;
   logic signed [10:0] exp_rnd;

   assign advance   = ~s2_valid_q | out_ready;
   assign in_ready  = ~s1_valid_q | advance;
   assign out_valid = s2_valid_q;
   assign out_data  = data_q;
   assign out_flags = flags_q;

   // S1: pick the normalization window from the product's top bit.
   always_comb begin
      s1_new         = '0;
      norm_hi        = prod_man[47];
      s1_new.sign    = res_sign;
      s1_new.nan     = |res_NANs;
      s1_new.invalid = res_NANs[1];
      s1_new.inf     = res_INF;
      s1_new.zero    = res_ZERO;
      if (norm_hi) begin
         s1_new.man    = prod_man[46:24];
         s1_new.guard  = prod_man[23];
         s1_new.sticky = |prod_man[22:0];
         s1_new.exp    = {exp_sum[9], exp_sum} + 11'd1;
      end else begin
         s1_new.man    = prod_man[45:23];
         s1_new.guard  = prod_man[22];
         s1_new.sticky = |prod_man[21:0];
         s1_new.exp    = {exp_sum[9], exp_sum};
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_d = s1_new;
         end
      end
   end

   // S2: round to nearest even; a mantissa carry-out bumps the exponent.
   always_comb begin
      round_up = s1_q.guard & (s1_q.sticky | s1_q.man[0]);
      man_rnd  = {1'b0, s1_q.man} + {23'd0, round_up};
      exp_s1   = $signed(s1_q.exp);
      exp_rnd  = exp_s1 + $signed({10'd0, man_rnd[23]});
      data_pk  = '0;
      flags_pk = '0;
      if (s1_q.nan) begin
         data_pk  = 32'h7FC0_0000;
         flags_pk = {s1_q.invalid, 3'b000};
      end else if (s1_q.inf) begin
         data_pk  = {s1_q.sign, 8'hFF, 23'd0};
      end else if (s1_q.zero) begin
         data_pk  = {s1_q.sign, 31'd0};
      end else if (exp_rnd >= 11'sd255) begin
         data_pk  = {s1_q.sign, 8'hFF, 23'd0};
         flags_pk = 4'b0101;
      end else if (exp_rnd <= 11'sd0) begin
         data_pk  = {s1_q.sign, 31'd0};
         flags_pk = 4'b0011;
      end else begin
         data_pk  = {s1_q.sign, exp_rnd[7:0], man_rnd[22:0]};
         flags_pk = {3'b000, s1_q.guard | s1_q.sticky};
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      data_d     = data_q;
      flags_d    = flags_q;
      if (advance) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            data_d  = data_pk;
            flags_d = flags_pk;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         data_q     <= '0;
         flags_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         data_q     <= data_d;
         flags_q    <= flags_d;
      end
   end

endmodule

// File: tb/tb_res_pack.sv
// Self-checking bench for res_pack: directed corner cases, backpressure, reset
// flush and a randomized run scored against an arithmetic reference model.
module tb_res_pack;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        res_sign;
   logic [1:0]  res_NANs;
   logic        res_INF;
   logic        res_ZERO;
   logic [47:0] prod_man;
   logic [9:0]  exp_sum;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_flags;

   res_pack dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res_sign  (res_sign),
      .res_NANs  (res_NANs),
      .res_INF   (res_INF),
      .res_ZERO  (res_ZERO),
      .prod_man  (prod_man),
      .exp_sum   (exp_sum),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_count = 0;
   int pop_count = 0;
   logic last_acc = 1'b0;
   logic lat_on   = 1'b0;
   logic use_dir  = 1'b0;
   logic [35:0] dir_val = '0;
   logic [35:0] exp_q[$];
   int          acc_q[$];

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: value-level rounding using the remainder against one half ulp.
   function automatic logic [35:0] model(input logic s, input logic [1:0] nans, input logic inf,
                                         input logic zero, input logic [47:0] p, input logic [9:0] es);
      longint one, m, rem, half;
      int e, sh;
      logic inx;
      one = 1;
      if (nans != 2'b00) return {nans[1], 3'b000, 32'h7FC0_0000};
      if (inf)  return {4'b0000, s, 8'hFF, 23'd0};
      if (zero) return {4'b0000, s, 31'd0};
      sh   = p[47] ? 24 : 23;
      m    = longint'(p) >> sh;
      rem  = longint'(p) & ((one << sh) - 1);
      half = one << (sh - 1);
      e    = int'($signed(es)) + ((sh == 24) ? 1 : 0);
      inx  = (rem != 0);
      if (rem > half || (rem == half && m[0])) m++;
      if (m == (one << 24)) begin
         m = one << 23;
         e++;
      end
      if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
      if (e <= 0)   return {4'b0011, s, 31'd0};
      return {3'b000, inx, s, e[7:0], m[22:0]};
   endfunction

   // One clock: observe at the falling edge, score, then move to just after the rising edge.
   task automatic step();
      logic exp_rdy;
      logic [35:0] front;
      @(negedge clk);
      cyc++;
      exp_rdy = (exp_q.size() < 2) || out_ready;
      check("in_ready", 36'(in_ready), 36'(exp_rdy));
      if (exp_q.size() == 0) begin
         check("idle_out_valid", 36'(out_valid), 36'd0);
      end else if (out_valid) begin
         front = exp_q[0];
         check("out_word", {out_flags, out_data}, front);
         if (out_ready) begin
            void'(exp_q.pop_front());
            if (lat_on) check("latency", 36'(cyc - acc_q[0]), 36'd2);
            void'(acc_q.pop_front());
            pop_count++;
         end
      end
      last_acc = in_valid && in_ready;
      if (last_acc) begin
         exp_q.push_back(use_dir ? dir_val :
                         model(res_sign, res_NANs, res_INF, res_ZERO, prod_man, exp_sum));
         acc_q.push_back(cyc);
         acc_count++;
         $display("cyc %0d accept sign=%0d nans=%0b inf=%0d zero=%0d prod=%h exp=%0d",
                  cyc, res_sign, res_NANs, res_INF, res_ZERO, prod_man, $signed(exp_sum));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_item(input logic s, input logic [1:0] n, input logic inf, input logic z,
                           input logic [47:0] p, input logic [9:0] e);
      res_sign = s; res_NANs = n; res_INF = inf; res_ZERO = z; prod_man = p; exp_sum = e;
   endtask

   task automatic gen_rand_item();
      int r, mode;
      logic [47:0] p;
      r    = $urandom_range(0, 15);
      mode = $urandom_range(0, 3);
      p    = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      if (p[47:46] == 2'b00) p[46] = 1'b1;
      if (mode == 0) begin
         if (p[47]) p[23:0] = 24'h80_0000; else p[22:0] = 23'h40_0000;
      end else if (mode == 1) begin
         if (p[47]) p[46:24] = '1; else p[45:23] = '1;
      end
      res_sign = 1'($urandom_range(0, 1));
      res_NANs = (r == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      res_INF  = (r == 1) || (r == 0 && $urandom_range(0, 1) == 1);
      res_ZERO = (r == 2) || (r <= 1 && $urandom_range(0, 1) == 1);
      prod_man = p;
      exp_sum  = 10'($urandom_range(0, 300) - 20);
   endtask

   task automatic directed(input logic s, input logic [1:0] n, input logic inf, input logic z,
                           input logic [47:0] p, input logic [9:0] e, input logic [35:0] want);
      set_item(s, n, inf, z, p, e);
      dir_val  = want;
      use_dir  = 1'b1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      use_dir  = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      int base_acc, base_pop;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_item(1'b0, 2'b00, 1'b0, 1'b0, 48'h4000_0000_0000, 10'd127);
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 36'(out_valid), 36'd0);
      check("rst_out_word", {out_flags, out_data}, 36'd0);
      rst_n = 1'b1;
      step();

      // Directed single items with latency tracking.
      lat_on = 1'b1; out_ready = 1'b1;
      directed(1'b0, 2'b00, 1'b0, 1'b0, 48'h4000_0000_0000, 10'd127, {4'b0000, 32'h3F80_0000});
      directed(1'b0, 2'b00, 1'b0, 1'b0, 48'h9000_0000_0000, 10'd127, {4'b0000, 32'h4010_0000});
      directed(1'b1, 2'b00, 1'b0, 1'b0, 48'h9000_0000_0000, 10'd254, {4'b0101, 32'hFF80_0000});
      directed(1'b1, 2'b10, 1'b1, 1'b0, 48'h4000_0000_0000, 10'd100, {4'b1000, 32'h7FC0_0000});
      directed(1'b0, 2'b00, 1'b0, 1'b0, 48'hFFFF_FF80_0000, 10'd100, {4'b0001, 32'h3300_0000});
      directed(1'b1, 2'b00, 1'b0, 1'b0, 48'h4000_0000_0000, 10'd0,   {4'b0011, 32'h8000_0000});
      directed(1'b1, 2'b00, 1'b1, 1'b1, 48'h4000_0000_0000, 10'd5,   {4'b0000, 32'hFF80_0000});
      directed(1'b0, 2'b00, 1'b0, 1'b1, 48'h4000_0000_0000, 10'd5,   {4'b0000, 32'h0000_0000});
      lat_on = 1'b0;

      // Backpressure: three back-to-back items against a stalled sink.
      out_ready = 1'b0;
      base_acc  = acc_count;
      base_pop  = pop_count;
      gen_rand_item();
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         if (last_acc) begin
            if (acc_count - base_acc < 3) gen_rand_item(); else in_valid = 1'b0;
         end
      end
      check("bp_accepts", 36'(acc_count - base_acc), 36'd2);
      check("bp_in_ready", 36'(in_ready), 36'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 20 && (in_valid || exp_q.size() > 0); k++) begin
         step();
         if (last_acc) begin
            if (acc_count - base_acc < 3) gen_rand_item(); else in_valid = 1'b0;
         end
      end
      check("bp_emitted", 36'(pop_count - base_pop), 36'd3);

      // Reset with two items in flight.
      gen_rand_item(); in_valid = 1'b1; step();
      gen_rand_item(); step();
      in_valid = 1'b0;
      check("pre_rst_valid", 36'(out_valid), 36'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 36'(out_valid), 36'd0);
      check("async_rst_word", {out_flags, out_data}, 36'd0);
      exp_q.delete();
      acc_q.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (5) step();

      // Randomized traffic with random backpressure.
      for (int k = 0; k < 600; k++) begin
         out_ready = ($urandom_range(0, 9) < 7);
         if (!in_valid || last_acc) begin
            if ($urandom_range(0, 3) != 0) begin
               gen_rand_item();
               in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         step();
      end

      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) step();
      check("drain_empty", 36'(exp_q.size()), 36'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
